// File: rtl/mips_bus_wait_injector.sv
// Wait-state injector between the CPU bus port and memory.
// Adds fixed or LFSR-random stalls per transfer and flags protocol abuse.
module mips_bus_wait_injector #(
  parameter int          WAIT_MODE  = 0,
  parameter int          FIXED_WAIT = 2,
  parameter int          WAIT_BITS  = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic [31:0] m_address,
  output logic        m_write,
  output logic        m_read,
  input  logic        m_waitrequest,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  output logic        protocol_error,
  output logic [15:0] xfer_count
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] MASK =
    4'((1 << WAIT_BITS) - 1);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [15:0] lfsr;
  logic        lat_write;
  logic        req;
  logic        both;
  logic        accept;
  logic        mismatch;
  logic        err_set;
  logic        enter_issue;
  logic [3:0]  w_val;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] v
  );
    return {1'b0, v[15:1]} ^
      (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign req    = read | write;
  assign both   = read & write;
  assign accept = (state == IDLE) && req && !both;

  assign waitrequest = req && (state != RESP);

  assign w_val = (WAIT_MODE == 0) ?
    4'(FIXED_WAIT) : (lfsr[3:0] & MASK);

  assign mismatch =
    (address != m_address) ||
    (write != lat_write) ||
    (read != !lat_write) ||
    (writedata != m_writedata);

  assign enter_issue =
    (state != ISSUE) && (state_n == ISSUE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (both) begin
          err_set = 1'b1;
        end else if (req) begin
          if (w_val != 4'd0) begin
            state_n = STALL;
            cnt_n   = w_val;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      STALL: begin
        if (!req) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else begin
          err_set = mismatch;
          cnt_n   = cnt - 4'd1;
          if (cnt == 4'd1) state_n = ISSUE;
        end
      end
      ISSUE: begin
        // The memory access runs to completion even if the CPU bails out.
        err_set = !req;
        if (!m_waitrequest) state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lfsr           <= LFSR_SEED;
      lat_write      <= 1'b0;
      m_address      <= 32'd0;
      m_writedata    <= 32'd0;
      m_byteenable   <= 4'd0;
      m_read         <= 1'b0;
      m_write        <= 1'b0;
      readdata       <= 32'd0;
      protocol_error <= 1'b0;
      xfer_count     <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (err_set) protocol_error <= 1'b1;
      if (accept) begin
        m_address    <= address;
        m_writedata  <= writedata;
        m_byteenable <= byteenable;
        lat_write    <= write;
        lfsr         <= lfsr_step(lfsr);
      end
      if (enter_issue) begin
        m_read  <= accept ? read : !lat_write;
        m_write <= accept ? write : lat_write;
      end
      if (state == ISSUE && !m_waitrequest) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
        if (m_read) readdata <= m_readdata;
      end
      if (state == RESP) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_wait_injector.sv
// Bench for mips_bus_wait_injector: five parameterisations share one
// CPU/memory stimulus; sel chooses whose outputs are checked.
module tb_mips_bus_wait_injector;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  logic        wr_a  [5];
  logic [31:0] rd_a  [5];
  logic [31:0] ma_a  [5];
  logic        mw_a  [5];
  logic        mr_a  [5];
  logic [31:0] mwd_a [5];
  logic [3:0]  mbe_a [5];
  logic        pe_a  [5];
  logic [15:0] xc_a  [5];

  int checks;
  int errors;
  int sel;

  logic        s_wr;
  logic [31:0] s_rd;
  logic [31:0] s_ma;
  logic        s_mw;
  logic        s_mr;
  logic [31:0] s_mwd;
  logic [3:0]  s_mbe;
  logic        s_pe;
  logic [15:0] s_xc;

  assign s_wr  = wr_a[sel];
  assign s_rd  = rd_a[sel];
  assign s_ma  = ma_a[sel];
  assign s_mw  = mw_a[sel];
  assign s_mr  = mr_a[sel];
  assign s_mwd = mwd_a[sel];
  assign s_mbe = mbe_a[sel];
  assign s_pe  = pe_a[sel];
  assign s_xc  = xc_a[sel];

  // 0: fixed 0, 1: fixed 3, 2: fixed 1, 3: fixed 2, 4: random 2-bit
  for (genvar g = 0; g < 5; g++) begin : g_dut
    mips_bus_wait_injector #(
      .WAIT_MODE (g == 4 ? 1 : 0),
      .FIXED_WAIT(g == 1 ? 3 : g == 2 ? 1 : g == 3 ? 2 : 0),
      .WAIT_BITS (g == 4 ? 2 : 3),
      .LFSR_SEED (16'hACE1)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .write         (write),
      .read          (read),
      .waitrequest   (wr_a[g]),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (rd_a[g]),
      .m_address     (ma_a[g]),
      .m_write       (mw_a[g]),
      .m_read        (mr_a[g]),
      .m_waitrequest (m_waitrequest),
      .m_writedata   (mwd_a[g]),
      .m_byteenable  (mbe_a[g]),
      .m_readdata    (m_readdata),
      .protocol_error(pe_a[g]),
      .xfer_count    (xc_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_step(
    input logic [15:0] v
  );
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    byteenable = '0;
    m_waitrequest = 1'b0;
    m_readdata = '0;
    #13;
    reset = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // One CPU transfer; entered and left 2 time units after a rising edge.
  task automatic xfer(
    input  bit          wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    input  int          mw,
    output int          stall,
    output int          strobes,
    output int          first,
    output logic [31:0] rdv
  );
    int left;
    bit done;
    left = mw;
    stall = -1;
    strobes = 0;
    first = -1;
    rdv = '0;
    done = 0;
    address = a;
    writedata = d;
    byteenable = be;
    read = !wr;
    write = wr;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (s_mr || s_mw) begin
        strobes++;
        if (first < 0) first = c;
        checks++;
        if ({s_mr, s_mw, s_ma, s_mbe} !==
            {!wr, wr, a, be} ||
            (wr && s_mwd !== d)) begin
          errors++;
          $display("FAIL strobe_fields got r%b w%b %h %h %b",
                   s_mr, s_mw, s_ma, s_mwd, s_mbe);
        end
        m_waitrequest = (left > 0);
        if (left > 0) left--;
      end else begin
        m_waitrequest = 1'b0;
      end
      if (!s_wr) begin
        rdv = s_rd;
        stall = c;
        done = 1;
      end else begin
        @(posedge clk);
        #2;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr %h", a);
    end
    @(posedge clk);
    #2;
    read = 1'b0;
    write = 1'b0;
    m_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      sel = i;
      #1;
      checks++;
      if ({s_wr, s_mr, s_mw, s_ma, s_mwd, s_mbe,
           s_rd, s_pe, s_xc} !== '0) begin
        errors++;
        $display("FAIL reset_state dut %0d got wr%b r%b w%b %h %h %h pe%b xc%0d",
                 i, s_wr, s_mr, s_mw, s_ma, s_mwd,
                 s_rd, s_pe, s_xc);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_fixed0_read();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 0;
    do_reset();
    m_readdata = 32'h03E00008;
    xfer(0, 32'hBFC00000, 32'h0, 4'hF, 0,
         st, sb, fs, rv);
    checks++;
    if (st !== 2) begin
      errors++;
      $display("FAIL f0_stall got %0d want 2", st);
    end
    checks++;
    if (rv !== 32'h03E00008) begin
      errors++;
      $display("FAIL f0_readdata got %h want 03e00008", rv);
    end
    checks++;
    if (sb !== 1) begin
      errors++;
      $display("FAIL f0_strobes got %0d want 1", sb);
    end
    checks++;
    if (s_xc !== 16'd1) begin
      errors++;
      $display("FAIL f0_xfer_count got %0d want 1", s_xc);
    end
    m_readdata = 32'h12345678;
    @(posedge clk);
    #2;
    checks++;
    if (s_rd !== 32'h03E00008) begin
      errors++;
      $display("FAIL f0_rd_hold got %h want 03e00008", s_rd);
    end
  endtask

  task automatic test_fixed3_write();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 1;
    do_reset();
    xfer(1, 32'h00001004, 32'hDEADBEEF, 4'b0110, 0,
         st, sb, fs, rv);
    checks++;
    if (st !== 5) begin
      errors++;
      $display("FAIL f3_stall got %0d want 5", st);
    end
    checks++;
    if (fs !== 4 || sb !== 1) begin
      errors++;
      $display("FAIL f3_strobe got first %0d n %0d want 4 1",
               fs, sb);
    end
    checks++;
    if (s_xc !== 16'd1 || s_pe !== 1'b0) begin
      errors++;
      $display("FAIL f3_status got xc %0d pe %b want 1 0",
               s_xc, s_pe);
    end
  endtask

  task automatic test_mem_wait();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 2;
    do_reset();
    m_readdata = 32'hCAFEF00D;
    xfer(0, 32'h00000200, 32'h0, 4'hF, 4,
         st, sb, fs, rv);
    checks++;
    if (st !== 7) begin
      errors++;
      $display("FAIL mw_stall got %0d want 7", st);
    end
    checks++;
    if (sb !== 5 || fs !== 2) begin
      errors++;
      $display("FAIL mw_strobes got n %0d first %0d want 5 2",
               sb, fs);
    end
    checks++;
    if (rv !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mw_readdata got %h want cafef00d", rv);
    end
  endtask

  task automatic test_random_b2b();
    logic [15:0] lf;
    int st, sb, fs, mw, w;
    logic [31:0] rv, a, d;
    sel = 4;
    do_reset();
    lf = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      w = int'(lf[1:0]);
      lf = model_step(lf);
      mw = $urandom_range(0, 2);
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      m_readdata = d;
      xfer(0, a, 32'h0, 4'hF, mw, st, sb, fs, rv);
      checks++;
      if (st !== w + 2 + mw || sb !== mw + 1 ||
          rv !== d) begin
        errors++;
        $display("FAIL rnd_xfer %0d got st %0d sb %0d rd %h want %0d %0d %h",
                 i, st, sb, rv, w + 2 + mw, mw + 1, d);
      end
    end
    checks++;
    if (s_xc !== 16'd8 || s_pe !== 1'b0) begin
      errors++;
      $display("FAIL rnd_status got xc %0d pe %b want 8 0",
               s_xc, s_pe);
    end
  endtask

  task automatic test_both();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 0;
    do_reset();
    read = 1'b1;
    write = 1'b1;
    address = 32'h40;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (s_wr !== 1'b1 || s_mr !== 1'b0 ||
          s_mw !== 1'b0) begin
        errors++;
        $display("FAIL both_hold cyc %0d got wr%b r%b w%b want 1 0 0",
                 c, s_wr, s_mr, s_mw);
      end
      @(posedge clk);
      #2;
    end
    checks++;
    if (s_pe !== 1'b1) begin
      errors++;
      $display("FAIL both_err got %b want 1", s_pe);
    end
    read = 1'b0;
    write = 1'b0;
    #1;
    checks++;
    if (s_wr !== 1'b0) begin
      errors++;
      $display("FAIL both_release got %b want 0", s_wr);
    end
    @(posedge clk);
    #2;
    m_readdata = 32'h0BADCAFE;
    xfer(0, 32'h80, 32'h0, 4'hF, 0, st, sb, fs, rv);
    checks++;
    if (st !== 2 || rv !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL both_after got st %0d rd %h want 2 0badcafe",
               st, rv);
    end
  endtask

  task automatic test_stall_abuse();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 1;
    do_reset();
    read = 1'b1;
    address = 32'h0000_1000;
    @(posedge clk);
    #2;
    address = 32'h0000_2000;
    @(posedge clk);
    #2;
    checks++;
    if (s_pe !== 1'b1 || s_ma !== 32'h0000_1000) begin
      errors++;
      $display("FAIL stall_change got pe %b ma %h want 1 00001000",
               s_pe, s_ma);
    end
    read = 1'b0;
    @(posedge clk);
    #2;
    m_readdata = 32'h55AA55AA;
    xfer(0, 32'h0000_3000, 32'h0, 4'hF, 0,
         st, sb, fs, rv);
    checks++;
    if (st !== 5 || rv !== 32'h55AA55AA ||
        s_xc !== 16'd1) begin
      errors++;
      $display("FAIL stall_drop got st %0d rd %h xc %0d want 5 55aa55aa 1",
               st, rv, s_xc);
    end
  endtask

  task automatic test_reset_mid();
    int st, sb, fs;
    logic [31:0] rv;
    sel = 3;
    do_reset();
    m_waitrequest = 1'b1;
    read = 1'b1;
    address = 32'h0000_0400;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (s_mr !== 1'b1) begin
      errors++;
      $display("FAIL rm_issue got m_read %b want 1", s_mr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({s_mr, s_mw, s_ma, s_mwd, s_mbe, s_rd,
         s_pe, s_xc} !== '0 || s_wr !== 1'b1) begin
      errors++;
      $display("FAIL rm_async got r%b w%b ma %h pe %b xc %0d wr %b",
               s_mr, s_mw, s_ma, s_pe, s_xc, s_wr);
    end
    read = 1'b0;
    m_waitrequest = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #2;
    m_readdata = 32'hA5A5_0001;
    xfer(0, 32'h0000_0500, 32'h0, 4'hF, 0,
         st, sb, fs, rv);
    checks++;
    if (st !== 4 || rv !== 32'hA5A5_0001 ||
        s_xc !== 16'd1) begin
      errors++;
      $display("FAIL rm_after got st %0d rd %h xc %0d want 4 a5a50001 1",
               st, rv, s_xc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 0;
    test_reset();
    test_fixed0_read();
    test_fixed3_write();
    test_mem_wait();
    test_random_b2b();
    test_both();
    test_stall_abuse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_wait_injector.md
Name: mips_bus_wait_injector

Overview:
- Bus-side stage inserted between the mips_cpu_bus memory port and the RAM model.
- Makes the CPU tolerate variable memory latency by adding wait states before each transfer, fixed or pseudo-random, on top of any waitrequest the memory asserts.
- Re-registers each CPU request, forwards it to memory, captures read data, and completes the transfer to the CPU in a single response cycle.
- Flags bus-protocol violations by the CPU.

Parameters:
- WAIT_MODE, 0: 0 = fixed wait count, 1 = LFSR-random wait count.
- FIXED_WAIT, 2: wait states inserted per transfer when WAIT_MODE=0 (0..15).
- WAIT_BITS, 3: random wait = lfsr[WAIT_BITS-1:0] when WAIT_MODE=1 (1..4).
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR; must be non-zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address.
- write  in  1  CPU write request.
- read  in  1  CPU read request.
- waitrequest  out  1  stall to the CPU.
- writedata  in  32  CPU write data.
- byteenable  in  4  CPU byte lanes.
- readdata  out  32  read data to the CPU, valid when read=1 and waitrequest=0.
- m_address  out  32  memory address (latched).
- m_write  out  1  memory write strobe.
- m_read  out  1  memory read strobe.
- m_waitrequest  in  1  memory stall.
- m_writedata  out  32  latched write data.
- m_byteenable  out  4  latched byte lanes.
- m_readdata  in  32  memory read data.
- protocol_error  out  1  sticky violation flag.
- xfer_count  out  16  count of completed transfers, wraps at 16'hFFFF→0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; m_read=m_write=0; m_address, m_writedata, readdata=0; m_byteenable=0; protocol_error=0; xfer_count=0; lfsr=LFSR_SEED.
  - Takes effect mid-transfer too. An in-flight memory access is dropped; no response is given.
- waitrequest is combinational: (read|write) && state!=RESP. It is 0 when no request is present.
- IDLE:
  - read^write=1: latch address, writedata, byteenable and direction. Wait count W = FIXED_WAIT, or lfsr[WAIT_BITS-1:0] sampled this edge.
  - The LFSR advances one step on this edge only. It is a Galois LFSR, right shift, tap mask 16'hB400.
  - Next state is STALL with counter=W if W>0, else ISSUE.
  - read&write=1: set protocol_error, remain IDLE, issue nothing. CPU waitrequest stays high.
- STALL:
  - Counter decrements each cycle. At counter==1 the next state is ISSUE.
  - CPU request dropped (read|write=0): set protocol_error, return to IDLE.
  - CPU address, direction or writedata differs from the latched value: set protocol_error, continue with the latched values.
- ISSUE:
  - m_read or m_write=1 with the latched fields. Memory strobes are registered outputs, asserted the cycle after ISSUE is entered.
  - Hold until m_waitrequest=0 at a rising edge. On a read, capture m_readdata into readdata on that edge.
  - Next state is RESP; strobes deassert on the same edge.
  - Never aborted by the CPU dropping its request; a drop sets protocol_error.
- RESP:
  - One cycle with CPU waitrequest=0; the transfer completes at the next edge.
  - xfer_count increments; next state is IDLE.
  - readdata holds its value until the next read capture.
- Latency with memory waitrequest=0: the CPU sees W+2 stalled cycles, then one completion cycle, i.e. W+3 cycles per transfer. A back-to-back request is accepted in the IDLE cycle after RESP.
- Each memory waitrequest cycle adds one cycle.
- protocol_error clears only on reset.

Test Plan:
- WAIT_MODE=0, FIXED_WAIT=0; read 0xBFC00000 with memory returning 0x03E00008 and zero waits → waitrequest high 2 cycles, low 1; readdata=0x03E00008; xfer_count=1.
- FIXED_WAIT=3; write 0x00001004, data 0xDEADBEEF, byteenable 4'b0110 → m_write pulses once, 5 cycles after the request; m_byteenable=0110, m_writedata=0xDEADBEEF; CPU stalled 5 cycles, completes on the 6th.
- FIXED_WAIT=1; memory holds m_waitrequest high for 4 cycles during ISSUE → m_read held steady 5 cycles; CPU completion arrives on cycle 8; single readdata capture.
- WAIT_MODE=1, WAIT_BITS=2, default seed; 8 consecutive reads → stall lengths match a software LFSR model exactly; xfer_count=8; protocol_error=0.
- read=write=1 in IDLE → protocol_error=1; no m_read/m_write; waitrequest stays high until the request is withdrawn.
- Assert reset low mid-ISSUE with FIXED_WAIT=2 → m_read falls asynchronously; all outputs at reset values; after release a new read completes normally.
